shift_add_mul32: RTL and testbench
==================================

// Module: shift_add_mul32
// PURPOSE
//  Sequential unsigned 32x32 -> 64-bit shift-and-add multiplier for the ALU multiply path.
//  Drives the 32-bit ripple adder FA_32bit once per cycle and consumes its Sum/Cout.
//  Takes one partial product per clock, so the ALU needs no combinational 32x32 array.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH bits; only 32 is verified
//  CNT_W   6    iteration counter width; must hold the value WIDTH
// PORTS
//  Clk      in   1   rising-edge clock
//  Reset    in   1   asynchronous, active-high reset
//  Start    in   1   request a multiply; sampled only in IDLE
//  A        in   32  multiplicand; captured on the Start edge
//  B        in   32  multiplier; captured on the Start edge
//  Busy     out  1   high in RUN and DONE
//  Done     out  1   one-cycle pulse; Product is valid while Done is high
//  Product  out  64  A*B; holds its value until the next accepted Start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, Busy=0, Done=0, Product=0, counter=0, internal regs=0.
//  States are IDLE, RUN and DONE. Done and Busy are Moore outputs decoded from state.
//  IDLE: when Start=1, on that edge:
//    - M<=A, Q<=B, P_hi<=0, cnt<=0
//    - state<=RUN
//  RUN, each edge:
//    - adder inputs are P_hi and (Q[0] ? M : 0), with Cin=0
//    - {P_hi,Q} <= {Cout,Sum,Q}>>1, a 65-bit shift right; Cout becomes bit 63
//    - cnt<=cnt+1
//    - when cnt==WIDTH-1: Product<={next P_hi, next Q} and state<=DONE
//  DONE: Done=1 for exactly one cycle, then state<=IDLE.
//  Latency: Start sampled at edge k -> Done high from edge k+WIDTH to k+WIDTH+1.
//  Initiation interval: WIDTH+2 cycles. Start in IDLE on the cycle after Done is accepted.
//  Start while Busy: ignored, with no effect on the operation in flight.
//  Start in DONE: ignored.
//  A and B may change freely after the capture edge.
//  Arithmetic is unsigned and cannot overflow: P_hi+M fits in 33 bits, held as Cout:Sum.
//  Boundary case 0xFFFFFFFF*0xFFFFFFFF must yield 0xFFFFFFFE_00000001 (exercises Cout every step).
//  Reset mid-RUN: the operation is aborted and no Done pulse is produced; Product returns to 0.
// CONFIGURATION
//  Macro MUL_ZERO_SKIP_EN.
//  Defined: Start in IDLE with A==0 or B==0 goes directly to DONE on the capture edge.
//    - Product<=0 on that edge
//    - Done is high in the following cycle (latency 1)
//    - RUN is never entered
//  Undefined: zero operands take the full WIDTH-cycle path. Result is 0, latency WIDTH.
//  All other behaviour is identical with or without the macro.
// STRUCTURE
//  Shared package alu_pkg:
//    - typedef mul_state_t for IDLE, RUN and DONE, encoded 2'b00, 2'b01 and 2'b10
//    - MUL_WIDTH = 32
//  Sub-module: one FA_32bit instance as the per-cycle adder.
//  No other sub-modules. The FSM, counter and shift registers are local.
// TESTING
//  1. Reset, then Start with A=3, B=5.
//     -> Busy=1 on the next cycle; Done 32 cycles after capture; Product=64'd15.
//  2. A=B=0xFFFFFFFF.
//     -> Product=64'hFFFFFFFE_00000001; Done pulse exactly one cycle wide.
//  3. A=0x12345678, B=0x9ABCDEF0; pulse Start again at cycles 5 and 20.
//     -> extra Starts ignored; Product=64'h0B00EA4E_242D2080; a single Done.
//  4. Start A=7, B=9; assert Reset at cycle 10.
//     -> immediately Busy=0, Done=0, Product=0, state IDLE; no later Done.
//     Then Start A=2, B=4 -> Product=8.
//  5. A=0, B=0xDEADBEEF.
//     -> with MUL_ZERO_SKIP_EN: Done 1 cycle after capture, Product=0.
//     -> without it: Done 32 cycles after capture, Product=0.
//  6. Back-to-back: Start 6*7 and hold Start high throughout.
//     -> Product=42; second op (A=10, B=11 presented from Done) accepted in IDLE; Product=110.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared ALU definitions for the multiply path.
//   - mul_state_t : FSM encoding of the sequential multiplier
//                   (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
//   - MUL_WIDTH   : operand width of the multiply path
//   - mul_busy()  : decodes the Busy indication from a state value
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

  // Busy covers the whole time an operation owns the multiplier, including
  // the single result cycle, so the ALU cannot issue into the DONE slot.
  function automatic logic mul_busy(input mul_state_t s);
    return (s == MUL_RUN) || (s == MUL_DONE);
  endfunction

endpackage : alu_pkg

// File: rtl/FA_32bit.sv
// ---------------------------------------------------------------------------
// FA_32bit
//   Ripple-carry adder used as the per-cycle partial-product adder of the
//   sequential multiplier. Purely combinational.
// Ports
//   A    in  W  addend
//   B    in  W  addend
//   Cin  in  1  carry into bit 0
//   Sum  out W  A + B + Cin, low W bits
//   Cout out 1  carry out of bit W-1
// ---------------------------------------------------------------------------
module FA_32bit #(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] Sum,
  output logic         Cout
);

  // The carry is threaded through the loop as a blocking variable so the
  // chain is a true ripple of full adders, one bit per iteration.
  always_comb begin : ripple
    logic carry;
    carry = Cin;
    Sum   = '0;
    for (int i = 0; i < W; i++) begin
      Sum[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end

endmodule : FA_32bit

// File: rtl/shift_add_mul32.sv
// ---------------------------------------------------------------------------
// shift_add_mul32
//   Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier.
//   One partial product is accumulated per clock through a single FA_32bit,
//   so the ALU needs no combinational multiplier array.
//
// Parameters
//   WIDTH  operand width (only 32 is verified); product is 2*WIDTH bits
//   CNT_W  iteration counter width; must be able to hold WIDTH
//
// Ports
//   Clk      in   1        rising-edge clock
//   Reset    in   1        asynchronous, active-high reset
//   Start    in   1        request a multiply; sampled only in IDLE
//   A        in   WIDTH    multiplicand, captured on the accepted Start edge
//   B        in   WIDTH    multiplier,   captured on the accepted Start edge
//   Busy     out  1        high in RUN and DONE
//   Done     out  1        one-cycle pulse; Product is valid while high
//   Product  out  2*WIDTH  A*B; holds until overwritten by the next result
//
// Configuration
//   MUL_ZERO_SKIP_EN  when defined, a Start in IDLE with A==0 or B==0 goes
//                     straight to DONE with Product=0 (RUN is skipped).
//                     When undefined, zero operands take the full path.
//
// Timing
//   Start accepted at edge k -> Done high from edge k+WIDTH to k+WIDTH+1.
//   Initiation interval is WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module shift_add_mul32
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // FSM, counter and operand/accumulator registers
  mul_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [WIDTH-1:0]     m_q,     m_d;     // multiplicand
  logic [WIDTH-1:0]     q_q,     q_d;     // multiplier, shifts out LSB-first;
                                          // low product bits shift in at top
  logic [WIDTH-1:0]     phi_q,   phi_d;   // upper half of running product
  logic [2*WIDTH-1:0]   prod_q,  prod_d;

  // Adder interface
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;

  // {Cout,Sum,Q} shifted right by one. The shifted-out Q[0] has already
  // been consumed to select the addend, so it is simply dropped.
  logic [2*WIDTH-1:0]   step_next;

`ifdef MUL_ZERO_SKIP_EN
  logic                 zero_op;
  assign zero_op = (A == '0) || (B == '0);
`endif

  assign add_b     = q_q[0] ? m_q : '0;
  assign step_next = {add_cout, add_sum, q_q[WIDTH-1:1]};

  FA_32bit #(
    .W (WIDTH)
  ) u_adder (
    .A    (phi_q),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    q_d     = q_q;
    phi_d   = phi_q;
    prod_d  = prod_q;

    case (state_q)
      MUL_IDLE: begin
        if (Start) begin
          m_d   = A;
          q_d   = B;
          phi_d = '0;
          cnt_d = '0;
`ifdef MUL_ZERO_SKIP_EN
          if (zero_op) begin
            prod_d  = '0;
            state_d = MUL_DONE;
          end else begin
            state_d = MUL_RUN;
          end
`else
          state_d = MUL_RUN;
`endif
        end
      end

      MUL_RUN: begin
        {phi_d, q_d} = step_next;
        cnt_d        = cnt_q + CNT_W'(1);
        // The final iteration publishes the freshly shifted value, not the
        // registered one, so Product is valid on the first DONE cycle.
        if (cnt_q == LAST_CNT) begin
          prod_d  = step_next;
          state_d = MUL_DONE;
        end
      end

      // Start is deliberately not sampled here; the ALU must see IDLE first.
      MUL_DONE: begin
        state_d = MUL_IDLE;
      end

      default: begin
        state_d = MUL_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      phi_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      q_q     <= q_d;
      phi_q   <= phi_d;
      prod_q  <= prod_d;
    end
  end

  // Moore outputs
  assign Busy    = mul_busy(state_q);
  assign Done    = (state_q == MUL_DONE);
  assign Product = prod_q;

endmodule : shift_add_mul32

// File: tb/tb_shift_add_mul32.sv
module tb_shift_add_mul32;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [63:0] Product;

  int n_pass  = 0;
  int n_total = 0;

  // Edges between the capture edge and the first cycle Done is observed.
  localparam int FULL_LAT = 32;
`ifdef MUL_ZERO_SKIP_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 32;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    bit          extra;   // pulse Start during RUN
  } vec_t;

  vec_t vecs[7];

  shift_add_mul32 dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain unsigned arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one multiply and check busy, latency, product and pulse width.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int exp_lat, input bit extra);
    int cyc;
    bit seen;
    @(negedge Clk);
    A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    chk({tag, " busy"}, 64'(Busy), 64'd1);
    cyc  = 0;
    seen = Done;
    while (!seen && cyc < 40) begin
      @(negedge Clk);
      Start = extra && (cyc == 5 || cyc == 20);
      A = $urandom;
      B = $urandom;
      @(posedge Clk); #1;
      cyc++;
      seen = Done;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " product"}, Product, exp_p);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk); #1;
    chk({tag, " done width"}, 64'(Done), 64'd0);
    chk({tag, " idle"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    int cyc;
    int dones;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd3,          32'd5,          64'd15,                 1'b0};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001,  1'b0};
    vecs[2] = '{32'h12345678,   32'h9ABCDEF0,   64'h0B00EA4E_242D2080,  1'b1};
    vecs[3] = '{32'd1,          32'd1,          64'd1,                  1'b0};
    vecs[4] = '{32'h80000000,   32'd2,          64'h00000001_00000000,  1'b0};
    vecs[5] = '{32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF,  1'b1};
    vecs[6] = '{32'h80000000,   32'h80000000,   64'h40000000_00000000,  1'b0};

    // Reset state
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
    #1;
    chk("reset busy",    64'(Busy), 64'd0);
    chk("reset done",    64'(Done), 64'd0);
    chk("reset product", Product,   64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, FULL_LAT, vecs[i].extra);

    // Zero operand
    run_op("zero", 32'd0, 32'hDEADBEEF, 64'd0, ZERO_LAT, 1'b0);

    // Randomized against the reference model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if (i == 3) ra = '0;
      run_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb),
             (ra == 0 || rb == 0) ? ZERO_LAT : FULL_LAT, i[0]);
    end

    // Back-to-back with Start held high
    @(negedge Clk);
    A = 32'd6; B = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    cyc = 0;
    while (!Done && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk("b2b first latency", 64'(cyc), 64'd32);
    chk("b2b first product", Product, 64'd42);
    @(negedge Clk);
    A = 32'd10; B = 32'd11;
    cyc = 0;
    @(posedge Clk); #1;
    cyc++;
    while (!Done && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk("b2b interval", 64'(cyc), 64'd34);
    chk("b2b second product", Product, 64'd110);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("b2b done width", 64'(Done), 64'd0);

    // Reset in the middle of RUN
    @(negedge Clk);
    A = 32'd7; B = 32'd9; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort busy",    64'(Busy), 64'd0);
    chk("abort done",    64'(Done), 64'd0);
    chk("abort product", Product,   64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done) dones++;
    end
    chk("abort no done", 64'(dones), 64'd0);
    run_op("after abort", 32'd2, 32'd4, 64'd8, FULL_LAT, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_shift_add_mul32
